// File: rtl/playfield_board_if.sv
// playfield_board_if
//   Bundle for the Tetris well occupancy store.
//   master : game / drawing logic side (drives probes, lock and read address)
//   slave  : playfield_board side
//   Signals:
//     chk_x/chk_y      4 packed candidate cells, block i at [i*CW +: CW]
//     chk_hit          candidate collides, is out of bounds, or board busy
//     lock_req/x/y     lock request and the 4 cells to lock
//     busy, lock_ack   lock in progress / 1-cycle completion pulse
//     lines_cleared    rows cleared by the last lock (held)
//     lock_err         last lock contained an out-of-range cell (held)
//     top_out          sticky game-over flag
//     clear_req        wipe the board while idle
//     rd_x/rd_y/rd_cell registered single-cell read port for video
//     lines_total      running cleared-row count (only with LINE_COUNT_EN)
interface playfield_board_if #(
  parameter int CW = 5
);
  logic [4*CW-1:0] chk_x;
  logic [4*CW-1:0] chk_y;
  logic            chk_hit;
  logic            lock_req;
  logic [4*CW-1:0] lock_x;
  logic [4*CW-1:0] lock_y;
  logic            busy;
  logic            lock_ack;
  logic [2:0]      lines_cleared;
  logic            lock_err;
  logic            top_out;
  logic            clear_req;
  logic [CW-1:0]   rd_x;
  logic [CW-1:0]   rd_y;
  logic            rd_cell;
`ifdef LINE_COUNT_EN
  logic [15:0]     lines_total;

  modport master (
    output chk_x, chk_y, lock_req, lock_x, lock_y, clear_req, rd_x, rd_y,
    input  chk_hit, busy, lock_ack, lines_cleared, lock_err, top_out, rd_cell,
           lines_total
  );
  modport slave (
    input  chk_x, chk_y, lock_req, lock_x, lock_y, clear_req, rd_x, rd_y,
    output chk_hit, busy, lock_ack, lines_cleared, lock_err, top_out, rd_cell,
           lines_total
  );
`else
  modport master (
    output chk_x, chk_y, lock_req, lock_x, lock_y, clear_req, rd_x, rd_y,
    input  chk_hit, busy, lock_ack, lines_cleared, lock_err, top_out, rd_cell
  );
  modport slave (
    input  chk_x, chk_y, lock_req, lock_x, lock_y, clear_req, rd_x, rd_y,
    output chk_hit, busy, lock_ack, lines_cleared, lock_err, top_out, rd_cell
  );
`endif
endinterface

// File: rtl/playfield_board.sv
// playfield_board
//   Occupancy store for the Tetris well (ROWS x COLS, row 0 at the top).
//   Answers collision probes, locks landed pieces, clears full rows and
//   serves a registered per-cell read port for the video logic.
//   Ports:
//     Clk    system clock, all state on the rising edge
//     Reset  synchronous, active-low
//     bus    playfield_board_if.slave (see interface header)
//   Optional feature: define LINE_COUNT_EN to add bus.lines_total, a
//   saturating 16-bit running count of cleared rows.
module playfield_board #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int CW   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  playfield_board_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] board_q [ROWS];
  logic [COLS-1:0] board_d [ROWS];
  logic [4*CW-1:0] lx_q, lx_d, ly_q, ly_d;
  logic [CW-1:0]   row_q, row_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      lines_q, lines_d;
  logic            err_q, err_d;
  logic            top_q, top_d;
  logic            rd_cell_q, rd_cell_d;
  logic            chk_hit;
`ifdef LINE_COUNT_EN
  logic [15:0]     total_q, total_d;
`endif

  function automatic logic in_range(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (x < CW'(COLS)) && (y < CW'(ROWS));
  endfunction

  // Collision probe; a busy board reports a hit so no move is accepted
  // against a grid that is being rewritten.
  always_comb begin
    logic [CW-1:0]   cx, cy;
    logic [COLS-1:0] rowv;
    cx      = '0;
    cy      = '0;
    rowv    = '0;
    chk_hit = (state_q != IDLE);
    for (int i = 0; i < 4; i++) begin
      cx = bus.chk_x[i*CW +: CW];
      cy = bus.chk_y[i*CW +: CW];
      if (!in_range(cx, cy)) begin
        chk_hit = 1'b1;
      end else begin
        rowv = board_q[cy] >> cx;
        if (rowv[0]) chk_hit = 1'b1;
      end
    end
  end

  // Video read port; out-of-range addresses read as empty.
  always_comb begin
    logic [COLS-1:0] rdrow;
    rdrow     = '0;
    rd_cell_d = 1'b0;
    if (in_range(bus.rd_x, bus.rd_y)) begin
      rdrow     = board_q[bus.rd_y] >> bus.rd_x;
      rd_cell_d = rdrow[0];
    end
  end

  always_comb begin
    logic [CW-1:0] wx, wy;
    logic [2:0]    fin_cnt;
    logic          enter_done;
`ifdef LINE_COUNT_EN
    logic [16:0]   sum;
`endif
    state_d    = state_q;
    board_d    = board_q;
    lx_d       = lx_q;
    ly_d       = ly_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    lines_d    = lines_q;
    err_d      = err_q;
    top_d      = top_q;
    wx         = '0;
    wy         = '0;
    fin_cnt    = cnt_q;
    enter_done = 1'b0;
`ifdef LINE_COUNT_EN
    total_d    = total_q;
    sum        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.lock_req) begin
          lx_d    = bus.lock_x;
          ly_d    = bus.lock_y;
          state_d = WRITE;
        end else if (bus.clear_req) begin
          for (int r = 0; r < ROWS; r++) board_d[r] = '0;
          top_d = 1'b0;
`ifdef LINE_COUNT_EN
          total_d = '0;
`endif
        end
      end
      WRITE: begin
        err_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
          wx = lx_q[i*CW +: CW];
          wy = ly_q[i*CW +: CW];
          if (in_range(wx, wy)) begin
            board_d[wy] = board_d[wy] | (COLS'(1) << wx);
            if (wy == '0) top_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        row_d   = CW'(ROWS - 1);
        cnt_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (&board_q[row_q]) begin
          state_d = SHIFT;
        end else if (row_q == '0) begin
          state_d    = DONE;
          enter_done = 1'b1;
          fin_cnt    = cnt_q;
        end else begin
          row_d = row_q - 1'b1;
        end
      end
      SHIFT: begin
        for (int r = 1; r < ROWS; r++) begin
          if (CW'(r) <= row_q) board_d[r] = board_q[r-1];
        end
        board_d[0] = '0;
        cnt_d = (cnt_q == 3'd4) ? cnt_q : cnt_q + 1'b1;
        // The re-check of this row is folded into the shift: the row that
        // lands here is board_q[row-1], so test it now. A full one shifts
        // again; otherwise this row is known not full and scanning resumes
        // one row up. This keeps one cycle per row plus one per clear.
        if (row_q == '0) begin
          state_d    = DONE;
          enter_done = 1'b1;
          fin_cnt    = cnt_d;
        end else if (&board_q[row_q - 1'b1]) begin
          state_d = SHIFT;
        end else begin
          row_d   = row_q - 1'b1;
          state_d = SCAN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Results are loaded on entry to DONE so they are valid with lock_ack.
    if (enter_done) begin
      lines_d = fin_cnt;
`ifdef LINE_COUNT_EN
      sum     = {1'b0, total_q} + 17'(fin_cnt);
      total_d = sum[16] ? 16'hFFFF : sum[15:0];
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      lx_q      <= '0;
      ly_q      <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      lines_q   <= '0;
      err_q     <= 1'b0;
      top_q     <= 1'b0;
      rd_cell_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) board_q[r] <= '0;
`ifdef LINE_COUNT_EN
      total_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      err_q     <= err_d;
      top_q     <= top_d;
      rd_cell_q <= rd_cell_d;
      for (int r = 0; r < ROWS; r++) board_q[r] <= board_d[r];
`ifdef LINE_COUNT_EN
      total_q   <= total_d;
`endif
    end
  end

  assign bus.chk_hit       = chk_hit;
  assign bus.busy          = (state_q != IDLE);
  assign bus.lock_ack      = (state_q == DONE);
  assign bus.lines_cleared = lines_q;
  assign bus.lock_err      = err_q;
  assign bus.top_out       = top_q;
  assign bus.rd_cell       = rd_cell_q;
`ifdef LINE_COUNT_EN
  assign bus.lines_total   = total_q;
`endif

endmodule

// File: tb/tb_playfield_board.sv
`define CHK(nm, got, exp) check(nm, 32'(got), 32'(exp))

module tb_playfield_board;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CW   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  playfield_board_if #(.CW(CW)) bus();

  playfield_board #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          model [ROWS][COLS];
  bit          m_top;
  int unsigned m_total;
  bit          cmp_en  = 1'b0;
  bit          prev_ok = 1'b0;
  int          prev_x, prev_y;
  int          n_locks = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_ok(input string nm, input bit ok, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [4*CW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [4*CW-1:0] v;
    v[0*CW +: CW] = CW'(a);
    v[1*CW +: CW] = CW'(b);
    v[2*CW +: CW] = CW'(c);
    v[3*CW +: CW] = CW'(d);
    return v;
  endfunction

  function automatic bit m_cell(input int x, input int y);
    if (x < 0 || x >= COLS || y < 0 || y >= ROWS) return 1'b0;
    return model[y][x];
  endfunction

  function automatic bit m_hit(input logic [4*CW-1:0] xs, input logic [4*CW-1:0] ys);
    for (int i = 0; i < 4; i++) begin
      int x, y;
      x = int'(xs[i*CW +: CW]);
      y = int'(ys[i*CW +: CW]);
      if (x >= COLS || y >= ROWS) return 1'b1;
      if (model[y][x]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_zero();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 1'b0;
  endtask

  task automatic m_lock(input logic [4*CW-1:0] xs, input logic [4*CW-1:0] ys,
                        output int cnt, output bit err);
    bit nb [ROWS][COLS];
    int dst;
    bit full;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int x, y;
      x = int'(xs[i*CW +: CW]);
      y = int'(ys[i*CW +: CW]);
      if (x < COLS && y < ROWS) begin
        model[y][x] = 1'b1;
        if (y == 0) m_top = 1'b1;
      end else begin
        err = 1'b1;
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) nb[r][c] = 1'b0;
    cnt = 0;
    dst = ROWS - 1;
    for (int s = ROWS - 1; s >= 0; s--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (!model[s][c]) full = 1'b0;
      if (full) begin
        cnt++;
      end else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = model[s][c];
        dst--;
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = nb[r][c];
    m_total = (m_total + cnt > 32'd65535) ? 32'd65535 : m_total + cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check_ok("chk_hit", bus.chk_hit === m_hit(bus.chk_x, bus.chk_y),
               32'(bus.chk_hit), 32'(m_hit(bus.chk_x, bus.chk_y)));
      check_ok("idle_busy", bus.busy === 1'b0, 32'(bus.busy), 32'd0);
      check_ok("idle_ack", bus.lock_ack === 1'b0, 32'(bus.lock_ack), 32'd0);
      if (prev_ok)
        check_ok("rd_cell", bus.rd_cell === m_cell(prev_x, prev_y),
                 32'(bus.rd_cell), 32'(m_cell(prev_x, prev_y)));
      prev_ok = 1'b1;
      prev_x  = int'(bus.rd_x);
      prev_y  = int'(bus.rd_y);
    end else begin
      prev_ok = 1'b0;
    end
  end

  task automatic do_lock(input logic [4*CW-1:0] xs, input logic [4*CW-1:0] ys,
                         input bit with_clear, output int lat, output int lc);
    int exp_cnt;
    bit exp_err;
    cmp_en        = 1'b0;
    bus.lock_x    = xs;
    bus.lock_y    = ys;
    bus.lock_req  = 1'b1;
    bus.clear_req = with_clear;
    m_lock(xs, ys, exp_cnt, exp_err);
    tick();
    bus.clear_req = 1'b0;
    lat = 1;
    lc  = -1;
    while (lat < 60 && bus.lock_ack !== 1'b1) begin
      check_ok("busy_during_lock", bus.busy === 1'b1, 32'(bus.busy), 32'd1);
      check_ok("chk_hit_while_busy", bus.chk_hit === 1'b1, 32'(bus.chk_hit), 32'd1);
      tick();
      lat++;
    end
    check_ok("lock_ack_seen", bus.lock_ack === 1'b1, 32'(bus.lock_ack), 32'd1);
    if (bus.lock_ack === 1'b1) begin
      check_ok("lock_latency", lat == 2 + ROWS + exp_cnt, 32'(lat), 32'(2 + ROWS + exp_cnt));
      check_ok("lines_cleared", int'(bus.lines_cleared) == exp_cnt,
               32'(bus.lines_cleared), 32'(exp_cnt));
      check_ok("lock_err", bus.lock_err === exp_err, 32'(bus.lock_err), 32'(exp_err));
      check_ok("top_out", bus.top_out === m_top, 32'(bus.top_out), 32'(m_top));
`ifdef LINE_COUNT_EN
      check_ok("lines_total", 32'(bus.lines_total) == m_total,
               32'(bus.lines_total), 32'(m_total));
`endif
      lc = int'(bus.lines_cleared);
    end
    bus.lock_req = 1'b0;
    tick();
    check_ok("busy_after_ack", bus.busy === 1'b0, 32'(bus.busy), 32'd0);
    check_ok("ack_one_cycle", bus.lock_ack === 1'b0, 32'(bus.lock_ack), 32'd0);
    check_ok("lines_cleared_held", int'(bus.lines_cleared) == exp_cnt,
             32'(bus.lines_cleared), 32'(exp_cnt));
    check_ok("lock_err_held", bus.lock_err === exp_err, 32'(bus.lock_err), 32'(exp_err));
    n_locks++;
    $display("lock %0d: x=%h y=%h clr=%0d latency=%0d cleared=%0d err=%0d top=%0d",
             n_locks, xs, ys, with_clear, lat, lc, exp_err, m_top);
    cmp_en = 1'b1;
  endtask

  task automatic do_clear();
    cmp_en        = 1'b0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    m_zero();
    m_top   = 1'b0;
    m_total = 0;
    $display("clear: board wiped, top_out=%0d", bus.top_out);
    cmp_en = 1'b1;
  endtask

  task automatic rd_lit(input int x, input int y, input bit exp, input string nm);
    bus.rd_x = CW'(x);
    bus.rd_y = CW'(y);
    tick();
    check_ok(nm, bus.rd_cell === exp, 32'(bus.rd_cell), 32'(exp));
  endtask

  task automatic chk_lit(input logic [4*CW-1:0] xs, input logic [4*CW-1:0] ys,
                         input bit exp, input string nm);
    bus.chk_x = xs;
    bus.chk_y = ys;
    #1;
    check_ok(nm, bus.chk_hit === exp, 32'(bus.chk_hit), 32'(exp));
  endtask

  task automatic sweep();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        bus.rd_x = CW'(x);
        bus.rd_y = CW'(y);
        tick();
      end
  endtask

  task automatic idle_rand(input int n);
    for (int k = 0; k < n; k++) begin
      bus.chk_x = pk($urandom_range(0, 11), $urandom_range(0, 11),
                     $urandom_range(0, 11), $urandom_range(0, 11));
      bus.chk_y = pk($urandom_range(8, 21), $urandom_range(8, 21),
                     $urandom_range(8, 21), $urandom_range(8, 21));
      bus.rd_x  = CW'($urandom_range(0, 11));
      bus.rd_y  = CW'($urandom_range(8, 21));
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lc;
    bus.chk_x = '0; bus.chk_y = '0; bus.lock_req = 1'b0;
    bus.lock_x = '0; bus.lock_y = '0; bus.clear_req = 1'b0;
    bus.rd_x = '0; bus.rd_y = '0;
    m_zero(); m_top = 1'b0; m_total = 0;

    rst_n = 1'b0;
    repeat (3) tick();
    check_ok("rst_busy", bus.busy === 1'b0, 32'(bus.busy), 32'd0);
    check_ok("rst_ack", bus.lock_ack === 1'b0, 32'(bus.lock_ack), 32'd0);
    check_ok("rst_lines", bus.lines_cleared === 3'd0, 32'(bus.lines_cleared), 32'd0);
    check_ok("rst_err", bus.lock_err === 1'b0, 32'(bus.lock_err), 32'd0);
    check_ok("rst_top", bus.top_out === 1'b0, 32'(bus.top_out), 32'd0);
    check_ok("rst_rd", bus.rd_cell === 1'b0, 32'(bus.rd_cell), 32'd0);
`ifdef LINE_COUNT_EN
    check_ok("rst_total", bus.lines_total === 16'd0, 32'(bus.lines_total), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    sweep();
    chk_lit(pk(0, 1, 2, 3), pk(0, 0, 0, 0), 1'b0, "t1_chk_empty");

    do_lock(pk(0, 1, 2, 3), pk(19, 19, 19, 19), 1'b0, lat, lc);
    check_ok("t2_latency", lat == 22, 32'(lat), 32'd22);
    check_ok("t2_lines", lc == 0, 32'(lc), 32'd0);
    rd_lit(2, 19, 1'b1, "t2_rd_2_19");
    chk_lit(pk(3, 4, 5, 6), pk(19, 18, 18, 18), 1'b1, "t2_chk_occupied");
    chk_lit(pk(10, 0, 1, 2), pk(0, 1, 1, 1), 1'b1, "t2_chk_x10");

    do_lock(pk(4, 5, 6, 7), pk(19, 19, 19, 19), 1'b0, lat, lc);
    do_lock(pk(8, 8, 8, 8), pk(16, 17, 18, 19), 1'b0, lat, lc);
    do_lock(pk(9, 5, 6, 7), pk(19, 18, 18, 18), 1'b0, lat, lc);
    check_ok("t3_lines", lc == 1, 32'(lc), 32'd1);
    check_ok("t3_latency", lat == 23, 32'(lat), 32'd23);
    rd_lit(8, 19, 1'b1, "t3_rd_8_19");
    rd_lit(9, 19, 1'b0, "t3_rd_9_19");

    for (int r = 16; r < 20; r++) begin
      do_lock(pk(0, 1, 2, 3), pk(r, r, r, r), 1'b0, lat, lc);
      do_lock(pk(4, 5, 6, 7), pk(r, r, r, r), 1'b0, lat, lc);
      do_lock(pk(8, 8, 8, 8), pk(r, r, r, r), 1'b0, lat, lc);
    end
    do_lock(pk(9, 9, 9, 9), pk(16, 17, 18, 19), 1'b0, lat, lc);
    check_ok("t4_lines", lc == 4, 32'(lc), 32'd4);
    check_ok("t4_latency", lat == 26, 32'(lat), 32'd26);
`ifdef LINE_COUNT_EN
    check_ok("t4_total", bus.lines_total === 16'd5, 32'(bus.lines_total), 32'd5);
`endif
    for (int r = 16; r < 20; r++)
      for (int c = 0; c < COLS; c++) rd_lit(c, r, 1'b0, "t4_empty");

    do_lock(pk(0, 1, 2, 3), pk(20, 15, 15, 15), 1'b0, lat, lc);
    check_ok("t5_err", bus.lock_err === 1'b1, 32'(bus.lock_err), 32'd1);
    rd_lit(1, 15, 1'b1, "t5_rd_1_15");
    rd_lit(0, 20, 1'b0, "t5_rd_oob");
    do_lock(pk(5, 5, 5, 5), pk(0, 1, 2, 3), 1'b0, lat, lc);
    check_ok("t5_top", bus.top_out === 1'b1, 32'(bus.top_out), 32'd1);
    check_ok("t5_err_clear", bus.lock_err === 1'b0, 32'(bus.lock_err), 32'd0);
    do_lock(pk(0, 0, 0, 0), pk(10, 10, 10, 10), 1'b0, lat, lc);
    check_ok("t5_top_sticky", bus.top_out === 1'b1, 32'(bus.top_out), 32'd1);
    do_clear();
    check_ok("t5_top_cleared", bus.top_out === 1'b0, 32'(bus.top_out), 32'd0);
    rd_lit(5, 0, 1'b0, "t5_rd_cleared");

    cmp_en       = 1'b0;
    bus.lock_x   = pk(0, 1, 2, 3);
    bus.lock_y   = pk(18, 18, 18, 18);
    bus.lock_req = 1'b1;
    tick();
    repeat (6) tick();
    check_ok("t6_busy_pre", bus.busy === 1'b1, 32'(bus.busy), 32'd1);
    rst_n        = 1'b0;
    bus.lock_req = 1'b0;
    tick();
    check_ok("t6_busy", bus.busy === 1'b0, 32'(bus.busy), 32'd0);
    check_ok("t6_ack", bus.lock_ack === 1'b0, 32'(bus.lock_ack), 32'd0);
    check_ok("t6_lines", bus.lines_cleared === 3'd0, 32'(bus.lines_cleared), 32'd0);
    check_ok("t6_top", bus.top_out === 1'b0, 32'(bus.top_out), 32'd0);
    rst_n = 1'b1;
    m_zero(); m_top = 1'b0; m_total = 0;
    $display("reset during scan");
    cmp_en = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      check_ok("t6_no_ack", bus.lock_ack === 1'b0, 32'(bus.lock_ack), 32'd0);
    end
    sweep();
    do_lock(pk(2, 3, 4, 5), pk(19, 19, 19, 19), 1'b0, lat, lc);
    do_lock(pk(2, 3, 4, 5), pk(18, 18, 18, 18), 1'b1, lat, lc);
    rd_lit(2, 19, 1'b1, "t6_lock_wins");
    rd_lit(5, 18, 1'b1, "t6_lock_written");
    do_clear();

    for (int k = 0; k < 45; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
      end else begin
        int xs[4], ys[4];
        for (int i = 0; i < 4; i++) begin
          xs[i] = $urandom_range(0, 9);
          ys[i] = $urandom_range(16, 19);
          if ($urandom_range(0, 15) == 0) xs[i] = $urandom_range(10, 15);
          if ($urandom_range(0, 15) == 0) ys[i] = $urandom_range(20, 25);
          if ($urandom_range(0, 19) == 0) ys[i] = 0;
        end
        do_lock(pk(xs[0], xs[1], xs[2], xs[3]), pk(ys[0], ys[1], ys[2], ys[3]),
                1'b0, lat, lc);
      end
      idle_rand($urandom_range(3, 10));
    end
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
